// File: rtl/cv_ctrl_pkg.sv
// Shared constants for the ColecoVision controller-port block: joy_i bit
// positions, keypad codes, spinner phase encoding and accumulator saturation.
package cv_ctrl_pkg;

  // Layout of one port's slice of joy_i (all bits active high)
  localparam int cv_joy_w_c      = 20;
  localparam int cv_joy_r_c      = 0;
  localparam int cv_joy_l_c      = 1;
  localparam int cv_joy_d_c      = 2;
  localparam int cv_joy_u_c      = 3;
  localparam int cv_joy_fire1_c  = 4;
  localparam int cv_joy_fire2_c  = 5;
  localparam int cv_joy_star_c   = 6;
  localparam int cv_joy_hash_c   = 7;
  localparam int cv_joy_key0_c   = 8;
  localparam int cv_joy_purple_c = 18;
  localparam int cv_joy_blue_c   = 19;

  // Keypad nibbles as seen on pins {1,2,3,4}
  localparam logic [3:0] cv_key_0_c      = 4'b0011;
  localparam logic [3:0] cv_key_1_c      = 4'b1110;
  localparam logic [3:0] cv_key_2_c      = 4'b1101;
  localparam logic [3:0] cv_key_3_c      = 4'b0110;
  localparam logic [3:0] cv_key_4_c      = 4'b0001;
  localparam logic [3:0] cv_key_5_c      = 4'b1001;
  localparam logic [3:0] cv_key_6_c      = 4'b0111;
  localparam logic [3:0] cv_key_7_c      = 4'b1100;
  localparam logic [3:0] cv_key_8_c      = 4'b1000;
  localparam logic [3:0] cv_key_9_c      = 4'b1011;
  localparam logic [3:0] cv_key_star_c   = 4'b1010;
  localparam logic [3:0] cv_key_hash_c   = 4'b0101;
  localparam logic [3:0] cv_key_purple_c = 4'b0100;
  localparam logic [3:0] cv_key_blue_c   = 4'b0010;
  localparam logic [3:0] cv_key_none_c   = 4'b1111;

  localparam logic [3:0] cv_key_digit_c [10] = '{
    cv_key_0_c, cv_key_1_c, cv_key_2_c, cv_key_3_c, cv_key_4_c,
    cv_key_5_c, cv_key_6_c, cv_key_7_c, cv_key_8_c, cv_key_9_c
  };

  // Quadrature phase {A,B}; forward order is 11 -> 10 -> 00 -> 01 -> 11
  typedef enum logic [1:0] {
    ph_11 = 2'b11,
    ph_10 = 2'b10,
    ph_00 = 2'b00,
    ph_01 = 2'b01
  } phase_t;

  function automatic phase_t phase_fwd(input phase_t ph);
    case (ph)
      ph_11:   return ph_10;
      ph_10:   return ph_00;
      ph_00:   return ph_01;
      default: return ph_11;
    endcase
  endfunction

  function automatic phase_t phase_back(input phase_t ph);
    case (ph)
      ph_11:   return ph_01;
      ph_01:   return ph_00;
      ph_00:   return ph_10;
      default: return ph_11;
    endcase
  endfunction

  // Symmetric clamp to +/-(2^(width-1)-1); the most negative code is never used
  function automatic int cv_sat(input int value, input int width);
    int lim;
    lim = (1 << (width - 1)) - 1;
    if (value > lim)  return lim;
    if (value < -lim) return -lim;
    return value;
  endfunction

endpackage

// File: rtl/cv_quad_gen.sv
// Per-port spinner quadrature generator: a signed step accumulator fed by
// strobed deltas and drained one step per divider tick, driving pins 7/9.
//
// state | meaning
// ph_11 | A=1 B=1 (reset / rest position)
// ph_10 | A=1 B=0
// ph_00 | A=0 B=0
// ph_01 | A=0 B=1
module cv_quad_gen
  import cv_ctrl_pkg::*;
#(
  parameter int DELTA_W = 8,
  parameter int ACC_W   = 10
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               tick,
  input  logic [DELTA_W-1:0] delta,
  input  logic               strobe,
  output logic               quad_a,
  output logic               quad_b
);

  phase_t                   phase_q, phase_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  int                       step;
  int                       sum;

  // Phase and accumulator registers; reset drops any pending steps
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      phase_q <= ph_11;
      acc_q   <= '0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
    end
  end

  // One step per tick toward zero, new delta folded in the same cycle
  always_comb begin
    phase_d = phase_q;
    step    = 0;
    if (tick) begin
      if (acc_q > 0) begin
        step    = 1;
        phase_d = phase_fwd(phase_q);
      end else if (acc_q < 0) begin
        step    = -1;
        phase_d = phase_back(phase_q);
      end
    end
    sum   = int'(acc_q) + (strobe ? int'($signed(delta)) : 0) - step;
    acc_d = ACC_W'(cv_sat(sum, ACC_W));
  end

  assign quad_a = phase_q[1];
  assign quad_b = phase_q[0];

endmodule

// File: rtl/cv_ctrl_ports.sv
// ColecoVision / SG-1000 controller ports: keypad and joystick nibble
// encoding with registered active-low pins, plus a spinner quadrature
// generator per port sharing one step-rate divider.
// Optional build macro CV_AUTOFIRE_EN adds AF_PERIOD and autofire_i.
module cv_ctrl_ports
  import cv_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DELTA_W   = 8,
  parameter int ACC_W     = 10,
  parameter int QUAD_DIV  = 4096
`ifdef CV_AUTOFIRE_EN
  ,
  parameter int AF_PERIOD = 1 << 20
`endif
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [NUM_PORTS*20-1:0]      joy_i,
  input  logic [NUM_PORTS-1:0]         sel_kp_n_i,
  input  logic [NUM_PORTS-1:0]         sel_joy_n_i,
  input  logic [NUM_PORTS*DELTA_W-1:0] spin_delta_i,
  input  logic [NUM_PORTS-1:0]         spin_strobe_i,
`ifdef CV_AUTOFIRE_EN
  input  logic [NUM_PORTS-1:0]         autofire_i,
`endif
  output logic [NUM_PORTS*4-1:0]       data_n_o,
  output logic [NUM_PORTS-1:0]         fire_n_o,
  output logic [NUM_PORTS-1:0]         quad_a_o,
  output logic [NUM_PORTS-1:0]         quad_b_o
);

  localparam int              DIV_W    = (QUAD_DIV > 1) ? $clog2(QUAD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QUAD_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // Shared free-running step-rate divider
  always_ff @(posedge clk_sys) begin
    if (reset)     div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [cv_joy_w_c-1:0] joy;
    logic [3:0]            kp_nib, js_nib, nib_d, data_q;
    logic                  kp_fire_n, js_fire_n, fire_d, fire_q;
    logic                  fire1_eff;

    assign joy = joy_i[p*cv_joy_w_c +: cv_joy_w_c];

`ifdef CV_AUTOFIRE_EN
    localparam int              AF_W    = (AF_PERIOD > 1) ? $clog2(AF_PERIOD) : 1;
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_PERIOD - 1);

    logic [AF_W-1:0] af_cnt_q;
    logic            af_on_q;

    // Autofire toggle timer; restarts asserted whenever fire1 is released
    always_ff @(posedge clk_sys) begin
      if (reset || !joy[cv_joy_fire1_c] || !autofire_i[p]) begin
        af_cnt_q <= AF_LAST;
        af_on_q  <= 1'b1;
      end else if (af_cnt_q == '0) begin
        af_cnt_q <= AF_LAST;
        af_on_q  <= ~af_on_q;
      end else begin
        af_cnt_q <= af_cnt_q - 1'b1;
      end
    end

    assign fire1_eff = joy[cv_joy_fire1_c] & (~autofire_i[p] | af_on_q);
`else
    assign fire1_eff = joy[cv_joy_fire1_c];
`endif

    // Keypad encoder; later assignments win, so lowest priority comes first
    always_comb begin
      kp_nib = cv_key_none_c;
      if (joy[cv_joy_blue_c])   kp_nib = cv_key_blue_c;
      if (joy[cv_joy_purple_c]) kp_nib = cv_key_purple_c;
      if (joy[cv_joy_hash_c])   kp_nib = cv_key_hash_c;
      if (joy[cv_joy_star_c])   kp_nib = cv_key_star_c;
      for (int k = 9; k >= 1; k--) begin
        if (joy[cv_joy_key0_c + k]) kp_nib = cv_key_digit_c[k];
      end
      if (joy[cv_joy_key0_c])   kp_nib = cv_key_0_c;
    end

    assign kp_fire_n = ~joy[cv_joy_fire2_c];
    assign js_nib    = ~{joy[cv_joy_u_c], joy[cv_joy_d_c], joy[cv_joy_l_c], joy[cv_joy_r_c]};
    assign js_fire_n = ~fire1_eff;

    // Open-collector style merge: a deselected half contributes all ones
    always_comb begin
      nib_d  = 4'b1111;
      fire_d = 1'b1;
      if (!sel_kp_n_i[p]) begin
        nib_d  = nib_d & kp_nib;
        fire_d = fire_d & kp_fire_n;
      end
      if (!sel_joy_n_i[p]) begin
        nib_d  = nib_d & js_nib;
        fire_d = fire_d & js_fire_n;
      end
    end

    // Registered pin drivers
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        data_q <= 4'b1111;
        fire_q <= 1'b1;
      end else begin
        data_q <= nib_d;
        fire_q <= fire_d;
      end
    end

    assign data_n_o[p*4 +: 4] = data_q;
    assign fire_n_o[p]        = fire_q;

    cv_quad_gen #(
      .DELTA_W (DELTA_W),
      .ACC_W   (ACC_W)
    ) u_quad (
      .clk_sys (clk_sys),
      .reset   (reset),
      .tick    (tick),
      .delta   (spin_delta_i[p*DELTA_W +: DELTA_W]),
      .strobe  (spin_strobe_i[p]),
      .quad_a  (quad_a_o[p]),
      .quad_b  (quad_b_o[p])
    );
  end

endmodule

// File: tb/tb_cv_ctrl_ports.sv
// Directed bench for cv_ctrl_ports: keypad/joystick encoding, select merging,
// spinner stepping, saturation, tick/strobe collision and reset mid-step.
module tb_cv_ctrl_ports;

  localparam int NP = 2;
  localparam int DW = 8;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic [NP*20-1:0] joy;
  logic [NP-1:0]   sel_kp_n, sel_joy_n, spin_strobe;
  logic [NP*DW-1:0] spin_delta;
  logic [NP*4-1:0] data_n;
  logic [NP-1:0]   fire_n, quad_a, quad_b;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  cv_ctrl_ports #(
    .NUM_PORTS (NP),
    .DELTA_W   (DW),
    .ACC_W     (4),
    .QUAD_DIV  (8)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .joy_i         (joy),
    .sel_kp_n_i    (sel_kp_n),
    .sel_joy_n_i   (sel_joy_n),
    .spin_delta_i  (spin_delta),
    .spin_strobe_i (spin_strobe),
    .data_n_o      (data_n),
    .fire_n_o      (fire_n),
    .quad_a_o      (quad_a),
    .quad_b_o      (quad_b)
  );

  function automatic logic [1:0] fwd(input logic [1:0] ph);
    case (ph)
      2'b11:   return 2'b10;
      2'b10:   return 2'b00;
      2'b00:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] back(input logic [1:0] ph);
    case (ph)
      2'b11:   return 2'b01;
      2'b01:   return 2'b00;
      2'b00:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] ph0();
    return {quad_a[0], quad_b[0]};
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe0(input logic [7:0] d);
    spin_delta[7:0] = d;
    spin_strobe[0]  = 1'b1;
    step();
    spin_strobe[0]  = 1'b0;
  endtask

  task automatic wait_change(output logic [1:0] ph, output bit ok);
    logic [1:0] prev;
    prev = ph0();
    ok   = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (ph0() != prev) ok = 1'b1;
    end
    ph = ph0();
  endtask

  task automatic count_steps(input int cycles, input bit dir_fwd,
                             output int n, output int wrong);
    logic [1:0] prev;
    prev  = ph0();
    n     = 0;
    wrong = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (ph0() != prev) begin
        n++;
        if (ph0() != (dir_fwd ? fwd(prev) : back(prev))) wrong++;
        prev = ph0();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    total++; if (data_n !== 8'hff) begin bad++; $display("FAIL reset_data got=%b want=11111111", data_n); end
    total++; if (fire_n !== 2'b11) begin bad++; $display("FAIL reset_fire got=%b want=11", fire_n); end
    total++; if (quad_a !== 2'b11) begin bad++; $display("FAIL reset_quad_a got=%b want=11", quad_a); end
    total++; if (quad_b !== 2'b11) begin bad++; $display("FAIL reset_quad_b got=%b want=11", quad_b); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_keypad();
    logic [19:0] vec [11];
    logic [3:0]  exp [11];
    vec = '{20'h02100, 20'h02000, 20'h20040, 20'h000c0, 20'h40080, 20'hc0000,
            20'h80000, 20'h10400, 20'h05000, 20'h04008, 20'h10000};
    exp = '{4'b0011, 4'b1001, 4'b1011, 4'b1010, 4'b0101, 4'b0100,
            4'b0010, 4'b1101, 4'b0001, 4'b0111, 4'b1000};
    sel_kp_n  = 2'b10;
    sel_joy_n = 2'b11;
    joy[19:0] = 20'h08800;   // keys 3 and 7
    step();
    total++; if (data_n[3:0] !== 4'b0110) begin bad++; $display("FAIL kp_3_over_7 got=%b want=0110", data_n[3:0]); end
    total++; if (data_n[7:4] !== 4'b1111) begin bad++; $display("FAIL kp_port1_idle got=%b want=1111", data_n[7:4]); end
    joy[19:0] = '0;
    step();
    total++; if (data_n[3:0] !== 4'b1111) begin bad++; $display("FAIL kp_release got=%b want=1111", data_n[3:0]); end
    for (int i = 0; i < 11; i++) begin
      joy[19:0] = vec[i];
      step();
      total++;
      if (data_n[3:0] !== exp[i]) begin
        bad++; $display("FAIL kp_table[%0d] got=%b want=%b", i, data_n[3:0], exp[i]);
      end
    end
    joy[19:0] = 20'h00020;   // fire2 in keypad half
    step();
    total++; if (fire_n[0] !== 1'b0) begin bad++; $display("FAIL kp_fire2 got=%b want=0", fire_n[0]); end
    joy[19:0] = '0;
    step();
  endtask

  task automatic test_joystick();
    sel_kp_n  = 2'b11;
    sel_joy_n = 2'b10;
    joy[19:0] = 20'h00019;   // U + R + fire1
    step();
    total++; if (data_n[3:0] !== 4'b0110) begin bad++; $display("FAIL js_ur got=%b want=0110", data_n[3:0]); end
    total++; if (fire_n[0] !== 1'b0) begin bad++; $display("FAIL js_fire1 got=%b want=0", fire_n[0]); end
    sel_kp_n  = 2'b10;
    sel_joy_n = 2'b11;
    step();
    total++; if (fire_n[0] !== 1'b1) begin bad++; $display("FAIL kp_fire_no_fire2 got=%b want=1", fire_n[0]); end
    total++; if (data_n[3:0] !== 4'b1111) begin bad++; $display("FAIL kp_no_key got=%b want=1111", data_n[3:0]); end
    sel_kp_n   = 2'b11;
    sel_joy_n  = 2'b01;
    joy[19:0]  = '0;
    joy[39:20] = 20'h00002;  // port1 L
    step();
    total++; if (data_n !== 8'b1101_1111) begin bad++; $display("FAIL js_port1_left got=%b want=11011111", data_n); end
    joy[39:20] = '0;
    sel_joy_n  = 2'b11;
    step();
  endtask

  task automatic test_both_selects();
    sel_kp_n  = 2'b10;
    sel_joy_n = 2'b10;
    joy[19:0] = 20'h00214;   // key 1 + D + fire1
    step();
    total++; if (data_n[3:0] !== 4'b1010) begin bad++; $display("FAIL both_data got=%b want=1010", data_n[3:0]); end
    total++; if (fire_n[0] !== 1'b0) begin bad++; $display("FAIL both_fire got=%b want=0", fire_n[0]); end
    sel_kp_n  = 2'b11;
    sel_joy_n = 2'b11;
    step();
    total++; if (data_n[3:0] !== 4'b1111) begin bad++; $display("FAIL none_data got=%b want=1111", data_n[3:0]); end
    total++; if (fire_n[0] !== 1'b1) begin bad++; $display("FAIL none_fire got=%b want=1", fire_n[0]); end
    joy[19:0] = '0;
    step();
  endtask

  task automatic test_spinner();
    logic [1:0] ph;
    logic [1:0] exp [5];
    bit         ok;
    int         n, wrong;
    exp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    strobe0(8'd3);
    for (int i = 0; i < 3; i++) begin
      wait_change(ph, ok);
      total++;
      if (!ok || ph !== exp[i]) begin
        bad++; $display("FAIL spin_fwd[%0d] got=%b changed=%0d want=%b", i, ph, ok, exp[i]);
      end
    end
    count_steps(30, 1'b1, n, wrong);
    total++; if (n !== 0) begin bad++; $display("FAIL spin_hold_fwd got=%0d steps want=0", n); end
    strobe0(8'hfe);
    for (int i = 3; i < 5; i++) begin
      wait_change(ph, ok);
      total++;
      if (!ok || ph !== exp[i]) begin
        bad++; $display("FAIL spin_back[%0d] got=%b changed=%0d want=%b", i, ph, ok, exp[i]);
      end
    end
    count_steps(30, 1'b0, n, wrong);
    total++; if (n !== 0) begin bad++; $display("FAIL spin_hold_back got=%0d steps want=0", n); end
    total++; if ({quad_a[1], quad_b[1]} !== 2'b11) begin bad++; $display("FAIL spin_port1_idle got=%b want=11", {quad_a[1], quad_b[1]}); end
  endtask

  task automatic test_saturation();
    logic [1:0] ph;
    bit         ok;
    int         n, wrong;
    strobe0(8'd1);           // align to a tick; phase 10 -> 00
    wait_change(ph, ok);
    total++; if (!ok || ph !== 2'b00) begin bad++; $display("FAIL sat_sync got=%b changed=%0d want=00", ph, ok); end
    strobe0(8'd7);
    strobe0(8'd7);
    repeat (5) step();
    strobe0(8'd1);           // lands on the tick with acc saturated at 7
    total++; if (ph0() !== 2'b01) begin bad++; $display("FAIL sat_collide_step got=%b want=01", ph0()); end
    count_steps(96, 1'b1, n, wrong);
    total++; if (n !== 7) begin bad++; $display("FAIL sat_remaining got=%0d want=7", n); end
    total++; if (wrong !== 0) begin bad++; $display("FAIL sat_direction got=%0d bad steps want=0", wrong); end
    total++; if (ph0() !== 2'b00) begin bad++; $display("FAIL sat_final got=%b want=00", ph0()); end
  endtask

  task automatic test_collision();
    logic [1:0] ph;
    bit         ok;
    int         n, wrong;
    strobe0(8'd1);           // align to a tick; phase 00 -> 01
    wait_change(ph, ok);
    total++; if (!ok || ph !== 2'b01) begin bad++; $display("FAIL col_sync got=%b changed=%0d want=01", ph, ok); end
    strobe0(8'd2);
    repeat (6) step();
    strobe0(8'd1);           // acc 2 + 1 - 1 = 2
    total++; if (ph0() !== 2'b11) begin bad++; $display("FAIL col_step got=%b want=11", ph0()); end
    count_steps(60, 1'b1, n, wrong);
    total++; if (n !== 2) begin bad++; $display("FAIL col_remaining got=%0d want=2", n); end
    total++; if (ph0() !== 2'b00) begin bad++; $display("FAIL col_final got=%b want=00", ph0()); end
  endtask

  task automatic test_reset_mid();
    int n, wrong;
    strobe0(8'd5);
    step();
    sel_kp_n  = 2'b10;
    joy[19:0] = 20'h00800;   // key 3 held across reset
    reset     = 1'b1;
    step();
    total++; if ({quad_a[0], quad_b[0]} !== 2'b11) begin bad++; $display("FAIL rst_mid_quad got=%b want=11", ph0()); end
    total++; if (data_n !== 8'hff) begin bad++; $display("FAIL rst_mid_data got=%b want=11111111", data_n); end
    step();
    joy[19:0] = '0;
    sel_kp_n  = 2'b11;
    reset     = 1'b0;
    count_steps(48, 1'b1, n, wrong);
    total++; if (n !== 0) begin bad++; $display("FAIL rst_mid_no_steps got=%0d want=0", n); end
    total++; if (ph0() !== 2'b11) begin bad++; $display("FAIL rst_mid_phase got=%b want=11", ph0()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    joy         = '0;
    sel_kp_n    = '1;
    sel_joy_n   = '1;
    spin_delta  = '0;
    spin_strobe = '0;
    test_reset();
    test_keypad();
    test_joystick();
    test_both_selects();
    test_spinner();
    test_saturation();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv_ctrl_ports.md
Name: cv_ctrl_ports

Overview:
- Parametrised ColecoVision/SG-1000 controller-port block for the emu top; replaces the inline keypad/joystick encoder.
- Generalised to NUM_PORTS ports, each producing the 4-bit keypad/joystick nibble and the fire line.
- Adds a spinner quadrature generator per port, driving pins 7/9 for Roller Controller / Super Action wheel games. These pins are currently tied high.
- Sits between the joystick/mouse mux and cv_console, in the clk_sys domain.

Parameters:
- NUM_PORTS, 2: number of controller ports.
- DELTA_W, 8: width of the signed spinner delta per strobe.
- ACC_W, 10: width of the signed spinner step accumulator.
- QUAD_DIV, 4096: clk_sys cycles per quadrature step (max step rate).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- joy_i  in  NUM_PORTS*20  per-port controller bits, active high:
  - [0] R, [1] L, [2] D, [3] U
  - [4] fire1, [5] fire2
  - [6] *, [7] #
  - [17:8] keys 0-9
  - [18] purple, [19] blue
- sel_kp_n_i  in  NUM_PORTS  console pin-5 select; low = keypad half.
- sel_joy_n_i  in  NUM_PORTS  console pin-8 select; low = joystick half.
- spin_delta_i  in  NUM_PORTS*DELTA_W  signed spinner movement.
- spin_strobe_i  in  NUM_PORTS  one-cycle valid for spin_delta_i.
- data_n_o  out  NUM_PORTS*4  pins {1,2,3,4}, active low.
- fire_n_o  out  NUM_PORTS  pin 6, active low.
- quad_a_o  out  NUM_PORTS  pin 7.
- quad_b_o  out  NUM_PORTS  pin 9.

Behaviour:
- Reset: data_n_o = 4'b1111, fire_n_o = 1, quad_a_o = quad_b_o = 1, accumulators 0, divider 0, phase 2'b11.
- Outputs are registered. Latency is 1 cycle from joy_i or select change to pins.
- Keypad half (sel_kp_n_i low): priority 0 > 1..9 > * > # > purple > blue. Codes:
  - 0 = 0011, 1 = 1110, 2 = 1101, 3 = 0110, 4 = 0001, 5 = 1001, 6 = 0111
  - 7 = 1100, 8 = 1000, 9 = 1011, * = 1010, # = 0101
  - purple = 0100, blue = 0010, none = 1111
  - Keypad-half fire = ~fire2.
- Joystick half (sel_joy_n_i low): nibble = ~{U,D,L,R}; fire = ~fire1.
- Both selects low: data = AND of the two nibbles; fire = AND of the two fires. Neither low: 1111 and 1.
- Spinner, per port:
  - Free-running divider wraps at QUAD_DIV-1 and emits tick.
  - On tick, acc > 0 steps the phase forward (11→10→00→01→11) and does acc−1.
  - On tick, acc < 0 steps the phase backward and does acc+1.
  - acc = 0 holds the phase.
  - Strobe and tick in the same cycle: acc_next = sat(acc + sext(delta) − step).
  - Saturate at ±(2^(ACC_W−1)−1). Never wrap.
  - quad_a_o = phase[1], quad_b_o = phase[0]. At most one bit changes per tick.
- Reset mid-step: the phase returns to 11 immediately and the pending accumulator is discarded.
- Ports are fully independent; the divider may be shared.

Optional Feature:
- CV_AUTOFIRE_EN defined:
  - Adds parameter AF_PERIOD (default 2^20) and input autofire_i [NUM_PORTS].
  - When autofire_i[n] = 1 and fire1 is held, the joystick-half fire toggles every AF_PERIOD cycles, starting asserted.
  - The toggle counter resets on fire1 release.
- Undefined: the port and logic are absent; fire follows fire1 directly.

Decomposition:
- cv_ctrl_pkg holds:
  - key-code localparams (cv_key_*_c)
  - joy_i bit-index constants
  - phase sequence constants
  - the saturation function
- Sub-module cv_quad_gen: one per port (accumulator, phase FSM, tick input), instantiated in a generate loop.

Test Plan:
- Keypad priority: port0 sel_kp_n = 0, keys 3 and 7 pressed → data_n_o[3:0] = 0110 next cycle; release both → 1111.
- Joystick half: sel_joy_n = 0, U+R pressed, fire1 = 1 → data_n_o = 0110, fire_n_o = 0. Switching to sel_kp_n with fire2 = 0 → fire_n_o = 1.
- Both selects low: key 1 (1110) plus D (1011) → data_n_o = 1010.
- Spinner: QUAD_DIV = 8, strobe delta = +3 → phases 10, 00, 01 at ticks 1-3, then hold. Delta = −2 → 00, 10.
- Saturation and collision: ACC_W = 4, strobe +7 then +7 → acc = 7. Strobe +1 coincident with a tick at acc = 7 → acc = 7.
- Reset mid-operation: assert reset with acc = 5 → quad pins = 11, data = 1111, no further steps after release.
